// File: rtl/edge5_pkg.sv
// edge5_pkg: shared constants, widths and types for the 5x5 gradient edge detector
//   S_W    : binomial smoothing weights {1,4,6,4,1}
//   D_W    : derivative weights {+1,+2,0,-2,-1}
//   grad_w : signed gradient / magnitude width for a W-bit intensity (W+8)
//   grad_t, mag_t : gradient and magnitude types at the default 8-bit intensity
package edge5_pkg;
  localparam int S_W [5] = '{1, 4, 6, 4, 1};
  localparam int D_W [5] = '{1, 2, 0, -2, -1};
  localparam int W_DEF = 8;
  function automatic int grad_w(input int w);
    return w + 8;
  endfunction
  typedef logic signed [W_DEF+7:0] grad_t;
  typedef logic [W_DEF+7:0] mag_t;
endpackage

// File: rtl/edge5_line_kernel.sv
// edge5_line_kernel: combinational 5-tap smoothing and derivative sums over one row or column
//   v     in  5*W : taps, tap i at bits [i*W +: W] (tap 0 = newest)
//   s_sum out W+4 : sum of S_W[i]*v[i], unsigned
//   d_sum out W+3 : sum of D_W[i]*v[i], signed
module edge5_line_kernel #(
  parameter int W = 8
) (
  input  logic [5*W-1:0]      v,
  output logic [W+3:0]        s_sum,
  output logic signed [W+2:0] d_sum
);
  import edge5_pkg::*;
  int sa, da;
  always_comb begin
    sa = 0;
    da = 0;
    for (int i = 0; i < 5; i++) begin
      sa += S_W[i] * int'(v[i*W +: W]);
      da += D_W[i] * int'(v[i*W +: W]);
    end
    s_sum = (W+4)'(sa);
    d_sum = (W+3)'(da);
  end
endmodule

// File: rtl/edge_detect5.sv
// edge_detect5: 5x5 smoothed-derivative edge detector with raster centre tracking
//   clk, rst_n (async, active low), clken (pixel enable shared with the window buffer)
//   iGrid      in  25*W : window, element k=5r+c at [(25-k)*W-1 -: W], centre r=2,c=2
//   iRGB       in  RGB  : centre colour aligned with iGrid
//   iSof       in  1    : start of frame, pixel (0,0) entering the buffer
//   iThresh    in  W+8  : edge threshold on |Gx|+|Gy|
//   iEdgeColor in  RGB  : colour substituted on edges
//   oRGB, oEdge, oValid, oX, oY : stage-3 result, pixel colour, edge flag, frame valid, centre position
// Optional build macro EDGE5_BORDER_MASK_EN: border centres never classify as edges.
// Pipeline: S1 row/column kernel sums + position, S2 Gx/Gy, S3 magnitude, compare, mux.
module edge_detect5
  import edge5_pkg::*;
#(
  parameter int P_BIT_WIDTH_IN = 8,
  parameter int P_RGB_WIDTH    = 24,
  parameter int P_H_ACTIVE     = 640,
  parameter int P_V_ACTIVE     = 480
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clken,
  input  logic [25*P_BIT_WIDTH_IN-1:0]  iGrid,
  input  logic [P_RGB_WIDTH-1:0]        iRGB,
  input  logic                          iSof,
  input  logic [P_BIT_WIDTH_IN+7:0]     iThresh,
  input  logic [P_RGB_WIDTH-1:0]        iEdgeColor,
  output logic [P_RGB_WIDTH-1:0]        oRGB,
  output logic                          oEdge,
  output logic                          oValid,
  output logic [$clog2(P_H_ACTIVE)-1:0] oX,
  output logic [$clog2(P_V_ACTIVE)-1:0] oY
);
  localparam int W  = P_BIT_WIDTH_IN;
  localparam int GW = grad_w(W);
  localparam int XW = $clog2(P_H_ACTIVE);
  localparam int YW = $clog2(P_V_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(P_H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(P_V_ACTIVE - 1);
  logic [5*W-1:0] row_v [5];
  logic [5*W-1:0] col_v [5];
  logic [W+3:0] hs_c [5];
  logic [W+3:0] vs_c [5];
  logic signed [W+2:0] hd_c [5];
  logic signed [W+2:0] vd_c [5];
  logic [W+3:0] hs1 [5];
  logic [W+3:0] vs1 [5];
  logic signed [W+2:0] hd1 [5];
  logic signed [W+2:0] vd1 [5];
  logic [XW-1:0] cx, nx, x1, x2;
  logic [YW-1:0] cy, ny, y1, y2;
  logic fa, fa_n, v1, v2;
  logic [P_RGB_WIDTH-1:0] rgb1, rgb2;
  logic signed [GW-1:0] gx2, gy2;
  logic [GW-1:0] ax, ay, mag;
  logic is_edge;
  int gx_s, gy_s;
  always_comb begin
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        row_v[r][c*W +: W] = iGrid[(25-(5*r+c))*W-1 -: W];
        col_v[c][r*W +: W] = iGrid[(25-(5*r+c))*W-1 -: W];
      end
  end
  for (genvar i = 0; i < 5; i++) begin : g_k
    edge5_line_kernel #(.W(W)) u_row (.v(row_v[i]), .s_sum(hs_c[i]), .d_sum(hd_c[i]));
    edge5_line_kernel #(.W(W)) u_col (.v(col_v[i]), .s_sum(vs_c[i]), .d_sum(vd_c[i]));
  end
  // Position of the centre of the window being accepted this cycle; a start of
  // frame places it two lines plus two pixels behind pixel (0,0).
  assign nx = iSof ? XW'(P_H_ACTIVE - 2) : (cx == X_LAST ? '0 : cx + XW'(1));
  assign ny = iSof ? YW'(P_V_ACTIVE - 3) :
              (cx == X_LAST ? (cy == Y_LAST ? '0 : cy + YW'(1)) : cy);
  assign fa_n = fa | iSof;
  // Rows and columns each factor both gradients, so summing the two
  // factorisations yields exactly 2*G and keeps every kernel output in use.
  always_comb begin
    gx_s = 0;
    gy_s = 0;
    for (int i = 0; i < 5; i++) begin
      gx_s += S_W[i] * int'(hd1[i]) + D_W[i] * int'(vs1[i]);
      gy_s += S_W[i] * int'(vd1[i]) + D_W[i] * int'(hs1[i]);
    end
  end
  assign ax  = gx2[GW-1] ? GW'(-gx2) : GW'(gx2);
  assign ay  = gy2[GW-1] ? GW'(-gy2) : GW'(gy2);
  assign mag = ax + ay;
`ifdef EDGE5_BORDER_MASK_EN
  logic bd_n, b1, b2;
  assign bd_n = nx < XW'(2) || nx > XW'(P_H_ACTIVE - 3) || ny < YW'(2) || ny > YW'(P_V_ACTIVE - 3);
  assign is_edge = !b2 && mag >= iThresh;
`else
  assign is_edge = mag >= iThresh;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cx <= '0;
      cy <= '0;
      fa <= 1'b0;
      v1 <= 1'b0;
      x1 <= '0;
      y1 <= '0;
      rgb1 <= '0;
      for (int i = 0; i < 5; i++) begin
        hs1[i] <= '0;
        vs1[i] <= '0;
        hd1[i] <= '0;
        vd1[i] <= '0;
      end
      v2 <= 1'b0;
      x2 <= '0;
      y2 <= '0;
      rgb2 <= '0;
      gx2 <= '0;
      gy2 <= '0;
`ifdef EDGE5_BORDER_MASK_EN
      b1 <= 1'b0;
      b2 <= 1'b0;
`endif
      oValid <= 1'b0;
      oX <= '0;
      oY <= '0;
      oEdge <= 1'b0;
      oRGB <= '0;
    end else if (clken) begin
      cx <= nx;
      cy <= ny;
      fa <= fa_n;
      v1 <= fa_n;
      x1 <= nx;
      y1 <= ny;
      rgb1 <= iRGB;
      for (int i = 0; i < 5; i++) begin
        hs1[i] <= hs_c[i];
        vs1[i] <= vs_c[i];
        hd1[i] <= hd_c[i];
        vd1[i] <= vd_c[i];
      end
      v2 <= v1;
      x2 <= x1;
      y2 <= y1;
      rgb2 <= rgb1;
      gx2 <= GW'(gx_s >>> 1);
      gy2 <= GW'(gy_s >>> 1);
`ifdef EDGE5_BORDER_MASK_EN
      b1 <= bd_n;
      b2 <= b1;
`endif
      oValid <= v2;
      oX <= x2;
      oY <= y2;
      oEdge <= is_edge;
      oRGB <= is_edge ? iEdgeColor : rgb2;
    end
endmodule

// File: tb/tb_edge_detect5.sv
// tb_edge_detect5: randomized scoreboard bench for edge_detect5 on a small 8x6 raster
module tb_edge_detect5;
  localparam int W = 8, RW = 24, H = 8, V = 6;
`ifdef EDGE5_BORDER_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif
  localparam int S [5] = '{1, 4, 6, 4, 1};
  localparam int D [5] = '{1, 2, 0, -2, -1};
  logic clk = 1'b0, rst_n = 1'b1, clken = 1'b0, iSof = 1'b0;
  logic [25*W-1:0] iGrid = '0;
  logic [RW-1:0] iRGB = '0, iEdgeColor = '0, oRGB;
  logic [W+7:0] iThresh = '0;
  logic oEdge, oValid;
  logic [2:0] oX, oY;
  edge_detect5 #(.P_BIT_WIDTH_IN(W), .P_RGB_WIDTH(RW), .P_H_ACTIVE(H), .P_V_ACTIVE(V)) dut (
    .clk(clk), .rst_n(rst_n), .clken(clken), .iGrid(iGrid), .iRGB(iRGB), .iSof(iSof),
    .iThresh(iThresh), .iEdgeColor(iEdgeColor), .oRGB(oRGB), .oEdge(oEdge),
    .oValid(oValid), .oX(oX), .oY(oY)
  );
  always #5 clk = ~clk;
  typedef struct {
    int m;
    logic [RW-1:0] rgb;
    int x;
    int y;
    bit border;
    int due;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, ce = 0, pos = 0;
  bit active = 1'b0;
  int pg [25];
  logic [RW-1:0] p_rgb;
  logic p_edge, p_valid;
  logic [2:0] p_x, p_y;
  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask
  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction
  task automatic rst_check(input string tag);
    chk({tag, "_oValid"}, oValid, 0);
    chk({tag, "_oEdge"}, oEdge, 0);
    chk({tag, "_oRGB"}, oRGB, 0);
    chk({tag, "_oX"}, oX, 0);
    chk({tag, "_oY"}, oY, 0);
  endtask
  task automatic rand_grid();
    int a, b, k;
    a = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    k = $urandom_range(1, 4);
    case ($urandom_range(0, 4))
      0: for (int i = 0; i < 25; i++) pg[i] = a;
      1: for (int i = 0; i < 25; i++) pg[i] = (i % 5) < k ? a : b;
      2: for (int i = 0; i < 25; i++) pg[i] = (i / 5) < k ? a : b;
      3: for (int i = 0; i < 25; i++) pg[i] = $urandom_range(0, 255);
      default: begin
        for (int i = 0; i < 25; i++) pg[i] = 0;
        pg[$urandom_range(0, 24)] = a;
      end
    endcase
  endtask
  // Drives one clock cycle of inputs and, for an accepted in-frame sample,
  // queues its expected gradient magnitude, colour and raster position.
  task automatic step(input bit en, input bit sof, input int thr);
    exp_t e;
    int gx, gy;
    @(negedge clk);
    clken = en;
    iSof = sof;
    iThresh = (W+8)'(thr);
    iRGB = RW'($urandom);
    iEdgeColor = RW'($urandom);
    for (int k = 0; k < 25; k++) iGrid[(25-k)*W-1 -: W] = W'(pg[k]);
    if (en) begin
      if (sof) begin
        active = 1'b1;
        pos = (V - 3) * H + H - 2;
      end else pos = (pos + 1) % (H * V);
      if (active) begin
        gx = 0;
        gy = 0;
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++) begin
            gx += S[r] * D[c] * pg[5*r+c];
            gy += S[c] * D[r] * pg[5*r+c];
          end
        e.m = iabs(gx) + iabs(gy);
        e.rgb = iRGB;
        e.x = pos % H;
        e.y = pos / H;
        e.border = e.x < 2 || e.x > H - 3 || e.y < 2 || e.y > V - 3;
        e.due = ce + 3;
        q.push_back(e);
      end
    end
  endtask
  always @(posedge clk) begin : mon
    bit en, live, ev, ed;
    exp_t e;
    en = clken;
    live = rst_n;
    if (live && en) ce++;
    #1;
    if (live && rst_n) begin
      if (!en) begin
        chk("hold_oValid", oValid, p_valid);
        chk("hold_oEdge", oEdge, p_edge);
        chk("hold_oRGB", oRGB, p_rgb);
        chk("hold_oX", oX, p_x);
        chk("hold_oY", oY, p_y);
      end else begin
        ev = q.size() > 0 && q[0].due == ce;
        chk("oValid", oValid, ev);
        if (ev) begin
          e = q.pop_front();
          ed = !(MASK && e.border) && e.m >= int'(iThresh);
          chk("oEdge", oEdge, ed);
          chk("oRGB", oRGB, ed ? iEdgeColor : e.rgb);
          chk("oX", oX, e.x);
          chk("oY", oY, e.y);
        end
      end
    end
    p_valid = oValid;
    p_edge = oEdge;
    p_rgb = oRGB;
    p_x = oX;
    p_y = oY;
  end
  initial begin
    #2 rst_n = 1'b0;
    #1 rst_check("init");
    for (int i = 0; i < 25; i++) pg[i] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      rand_grid();
      step(1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 16000));
    end
    for (int i = 0; i < 25; i++) pg[i] = 100;
    step(1'b1, 1'b1, 1);
    repeat (4) step(1'b1, 1'b0, 1);
    for (int i = 0; i < 25; i++) pg[i] = (i % 5) < 2 ? 255 : 0;
    repeat (4) step(1'b1, 1'b0, 1000);
    for (int i = 0; i < 25; i++) pg[i] = 0;
    pg[0] = 1;
    repeat (4) step(1'b1, 1'b0, 2);
    repeat (4) step(1'b1, 1'b0, 3);
    rand_grid();
    repeat (2) step(1'b1, 1'b0, 500);
    repeat (5) step(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 16000));
    repeat (3) step(1'b1, 1'b0, 500);
    repeat (600) begin
      rand_grid();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0, $urandom_range(0, 16000));
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 rst_check("async");
    q.delete();
    active = 1'b0;
    pos = 0;
    clken = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      rand_grid();
      step(1'b1, 1'b0, $urandom_range(0, 16000));
    end
    step(1'b1, 1'b1, 4000);
    repeat (200) begin
      rand_grid();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0, $urandom_range(0, 16000));
    end
    repeat (3) step(1'b1, 1'b0, 8000);
    repeat (2) step(1'b0, 1'b0, 8000);
    chk("inflight", q.size(), 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
